// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one of three register-file write requesters
// per cycle, with a registered write port and a saturating write counter.
module reg_write_arbiter #(
  parameter int N  = 16,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [2:0]      req_valid,
  input  logic [3*AW-1:0] req_addr,
  input  logic [3*N-1:0]  req_data,
  output logic [2:0]      req_ready,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [N-1:0]    wr_data,
  output logic [1:0]      wr_src,
  output logic [7:0]      wr_count
);

  logic [1:0]    last_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [N-1:0]  wr_data_q;
  logic [1:0]    wr_src_q;
  logic [7:0]    wr_count_q;

  logic [1:0]    last_eff;
  logic          found;
  logic [1:0]    gnt_idx;
  logic [2:0]    ready_d;
  logic          xfer;
  logic [AW-1:0] wr_addr_d;
  logic [N-1:0]  wr_data_d;

  // An illegal last=3 is folded onto 2 so requester 0 is searched first.
  assign last_eff = (last_q == 2'd3) ? 2'd2 : last_q;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found   = 1'b0;
    gnt_idx = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (int'(last_eff) + k) % 3;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = 2'(idx);
      end
    end
    ready_d = 3'b000;
    if (!rst && !stall && found) begin
      ready_d = 3'b001 << gnt_idx;
    end
  end

  assign req_ready = ready_d;
  assign xfer      = |(req_valid & ready_d);
  assign wr_addr_d = req_addr[gnt_idx*AW +: AW];
  assign wr_data_d = req_data[gnt_idx*N +: N];

  // Register the granted write and track grant history and write count.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 2'd2;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_src_q   <= 2'd0;
      wr_count_q <= 8'd0;
    end else begin
      wr_en_q <= xfer;
      if (xfer) begin
        last_q    <= gnt_idx;
        wr_addr_q <= wr_addr_d;
        wr_data_q <= wr_data_d;
        wr_src_q  <= gnt_idx;
      end
      if (wr_en_q && wr_count_q != 8'hFF) begin
        wr_count_q <= wr_count_q + 8'd1;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_src   = wr_src_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter.
// Hand-computed expectations checked with immediate assertions.
module tb_reg_write_arbiter;

  localparam int N  = 16;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic [2:0]      req_valid;
  logic [3*AW-1:0] req_addr;
  logic [3*N-1:0]  req_data;
  logic [2:0]      req_ready;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [N-1:0]    wr_data;
  logic [1:0]      wr_src;
  logic [7:0]      wr_count;

  int vectors = 0;
  int miscompares = 0;

  reg_write_arbiter #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_src(wr_src), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag,
                        input logic [31:0] src,
                        input logic [31:0] addr,
                        input logic [31:0] data);
    chk({tag, ".en"},   32'(wr_en),   32'd1);
    chk({tag, ".src"},  32'(wr_src),  src);
    chk({tag, ".addr"}, 32'(wr_addr), addr);
    chk({tag, ".data"}, 32'(wr_data), data);
  endtask

  initial begin
    rst       = 1'b1;
    stall     = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    chk("rst_en",    32'(wr_en),    32'd0);
    chk("rst_addr",  32'(wr_addr),  32'd0);
    chk("rst_data",  32'(wr_data),  32'd0);
    chk("rst_src",   32'(wr_src),   32'd0);
    chk("rst_count", 32'(wr_count), 32'd0);

    // Three-way contest, each requester dropping after its grant.
    rst      = 1'b0;
    req_addr = {4'd3, 4'd2, 4'd1};
    req_data = {16'h3333, 16'h2222, 16'h1111};
    #1;
    chk("rr_rdy0", 32'(req_ready), 32'b001);
    tick();
    chk_wr("rr_w0", 32'd0, 32'd1, 32'h1111);
    req_valid = 3'b110;
    #1;
    chk("rr_rdy1", 32'(req_ready), 32'b010);
    tick();
    chk_wr("rr_w1", 32'd1, 32'd2, 32'h2222);
    req_valid = 3'b100;
    #1;
    chk("rr_rdy2", 32'(req_ready), 32'b100);
    tick();
    chk_wr("rr_w2", 32'd2, 32'd3, 32'h3333);
    req_valid = 3'b000;
    tick();
    chk("rr_idle_en",   32'(wr_en),    32'd0);
    chk("rr_idle_data", 32'(wr_data),  32'h3333);
    chk("rr_idle_src",  32'(wr_src),   32'd2);
    chk("rr_count",     32'(wr_count), 32'd3);

    // Two continuous requesters alternate.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 3'b011;
    req_addr  = {4'd0, 4'd5, 4'd4};
    req_data  = {16'h0, 16'h00A1, 16'h00A0};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_rdy", 32'(req_ready),
          (i % 2 == 0) ? 32'b001 : 32'b010);
      tick();
      chk_wr("alt_w", 32'(i % 2), 32'(4 + i % 2),
             32'(16'h00A0 + 16'(i % 2)));
    end
    req_valid = 3'b000;
    tick();
    chk("alt_en0",   32'(wr_en),    32'd0);
    chk("alt_count", 32'(wr_count), 32'd4);

    // Stall for two cycles with requester 1 pending.
    req_valid = 3'b010;
    stall     = 1'b1;
    #1;
    chk("stl_rdy0", 32'(req_ready), 32'd0);
    tick();
    chk("stl_en0", 32'(wr_en), 32'd0);
    chk("stl_rdy1", 32'(req_ready), 32'd0);
    tick();
    chk("stl_en1", 32'(wr_en), 32'd0);
    stall = 1'b0;
    #1;
    chk("stl_rdy2", 32'(req_ready), 32'b010);
    tick();
    chk_wr("stl_w", 32'd1, 32'd5, 32'h00A1);
    req_valid = 3'b000;
    tick();
    chk("stl_en2",   32'(wr_en),    32'd0);
    chk("stl_count", 32'(wr_count), 32'd5);

    // Reset right after a grant to requester 2 discards the write port.
    req_valid = 3'b100;
    req_addr  = {4'd5, 4'd0, 4'd0};
    req_data  = {16'hBEEF, 16'h0, 16'h0};
    #1;
    chk("rb_rdy", 32'(req_ready), 32'b100);
    tick();
    chk_wr("rb_w", 32'd2, 32'd5, 32'hBEEF);
    rst       = 1'b1;
    req_valid = 3'b111;
    #1;
    chk("rb_rdy_rst", 32'(req_ready), 32'd0);
    tick();
    chk("rb_en",    32'(wr_en),    32'd0);
    chk("rb_addr",  32'(wr_addr),  32'd0);
    chk("rb_data",  32'(wr_data),  32'd0);
    chk("rb_src",   32'(wr_src),   32'd0);
    chk("rb_count", 32'(wr_count), 32'd0);
    rst      = 1'b0;
    req_addr = {4'd9, 4'd8, 4'd6};
    req_data = {16'h0C0C, 16'h0B0B, 16'h0A0A};
    #1;
    chk("rb_rdy_first", 32'(req_ready), 32'b001);
    tick();
    chk_wr("rb_w0", 32'd0, 32'd6, 32'h0A0A);
    req_valid = 3'b000;
    tick();

    // Same address from requesters 0 and 1; last grant was 0, so 1 first.
    req_valid = 3'b011;
    req_addr  = {4'd0, 4'd7, 4'd7};
    req_data  = {16'h0, 16'h5555, 16'hAAAA};
    tick();
    chk_wr("sa_w0", 32'd1, 32'd7, 32'h5555);
    req_valid = 3'b001;
    tick();
    chk_wr("sa_w1", 32'd0, 32'd7, 32'hAAAA);
    req_valid = 3'b000;
    tick();
    chk("sa_en",   32'(wr_en),   32'd0);
    chk("sa_data", 32'(wr_data), 32'hAAAA);

    // Saturation of the write counter.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 3'b001;
    for (int k = 1; k <= 305; k++) begin
      tick();
      if (k == 100) chk("sat_100", 32'(wr_count), 32'd99);
      if (k == 255) chk("sat_255", 32'(wr_count), 32'd254);
      if (k == 256) chk("sat_256", 32'(wr_count), 32'd255);
      if (k == 300) chk("sat_300", 32'(wr_count), 32'd255);
    end
    chk("sat_en",  32'(wr_en),    32'd1);
    chk("sat_end", 32'(wr_count), 32'd255);
    req_valid = 3'b000;
    tick();
    tick();
    chk("sat_hold", 32'(wr_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter N, default 16, data width of one register-file word.
REQ-002 Parameter AW, default 4, register address width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 stall  input  1  when 1, no new request is accepted this cycle.
REQ-007 req_valid  input  3  per-requester write request (bit 0 ALU, bit 1 memory load, bit 2 debug).
REQ-008 req_addr  input  3*AW  destination addresses, requester i in bits [i*AW +: AW].
REQ-009 req_data  input  3*N  write data, requester i in bits [i*N +: N].
REQ-010 req_ready  output  3  one-hot-or-zero grant, combinational.
REQ-011 wr_en  output  1  register-file write/load enable, registered.
REQ-012 wr_addr  output  AW  registered write address.
REQ-013 wr_data  output  N  registered write data.
REQ-014 wr_src  output  2  registered index of the granted requester (0..2).
REQ-015 wr_count  output  8  saturating count of completed writes.

Function
REQ-016 A transfer from requester i SHALL occur in the cycle where req_valid[i] and req_ready[i] are both 1.
REQ-017 At most one req_ready bit SHALL be 1 in any cycle.
REQ-018 req_ready SHALL be all-zero whenever rst=1, stall=1, or req_valid=0.
REQ-019 The grant SHALL follow round-robin order: search starts at (last+1) mod 3, where last is the 2-bit index of the most recently granted requester.
REQ-020 last SHALL update to the granted index only in a cycle with a transfer; otherwise it holds.
REQ-021 A transfer in cycle t SHALL produce wr_en=1 with the matching wr_addr, wr_data, and wr_src in cycle t+1 (latency 1).
REQ-022 In any cycle t with no transfer, wr_en SHALL be 0 in cycle t+1; wr_addr, wr_data, and wr_src SHALL hold their previous values.
REQ-023 Back-to-back transfers SHALL produce wr_en=1 on consecutive cycles, giving a throughput of one write per cycle.
REQ-024 A requester with req_valid held continuously SHALL be granted within 3 cycles in which stall=0 (no starvation).
REQ-025 Requesters SHALL hold req_addr and req_data stable until accepted; the arbiter does not buffer an unaccepted request.
REQ-026 Same-address requests from different requesters SHALL be serialized in grant order, so the later grant's data is the final register contents.
REQ-027 wr_count SHALL increment by 1 on each cycle with wr_en=1 and saturate at 255.
REQ-028 last=3 SHALL never occur; if reached, the arbiter SHALL treat it as last=2.

Reset
REQ-029 With rst=1 at a rising edge, the following SHALL be cleared: wr_en=0, wr_addr=0, wr_data=0, wr_src=0, wr_count=0, last=2, so requester 0 has highest priority after reset.
REQ-030 rst SHALL take precedence over stall and all requests; a write scheduled for the cycle after the reset edge SHALL be discarded (wr_en=0).
REQ-031 The first transfer SHALL be allowed in the first cycle with rst=0.

Verification
REQ-032 After reset, apply req_valid=3'b111 with addresses 1, 2, 3 and data 0x1111, 0x2222, 0x3333, each requester dropping valid after its grant. Required: wr_en=1 for 3 consecutive cycles with wr_src 0, 1, 2 and the matching addr/data.
REQ-033 Hold req_valid=3'b011 continuously. Required: grants alternate 0, 1, 0, 1, and wr_count=4 after 4 writes.
REQ-034 With req_valid[1]=1, raise stall=1 for 2 cycles, then drop it. Required: req_ready=0 and no wr_en pulse during the stall; exactly one write (wr_src=1) in the cycle after the first non-stall transfer.
REQ-035 Assert rst in the cycle after requester 2 is granted (addr 5, data 0xBEEF). Required: wr_en=0 after the reset edge, all outputs 0, and requester 0 wins the next 3-way contest.
REQ-036 Keep one requester continuously valid for 300 cycles. Required: wr_count reads 255 and stays there.
REQ-037 Requesters 0 and 1 both target addr 7 with data 0xAAAA and 0x5555. Required: two writes in grant order, with the last write to addr 7 carrying the later grant's data.
